apb_burst_accumulator: RTL and testbench

APB read master that fetches a parametrised burst of consecutive words from a slave and returns their sum, with error reporting and back-to-back burst chaining. It is the parametrised successor to the team's fixed two-word APB read-and-add master and sits between a compute requester and an APB slave. Width, burst length, address stride and sum width are all generics.

---
 rtl/apb_burst_accumulator_pkg.sv | 20 ++
 rtl/apb_burst_accumulator_if.sv | 24 ++
 rtl/apb_burst_accumulator.sv | 141 ++++++++++++++
 tb/tb_apb_burst_accumulator.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_burst_accumulator_pkg.sv
// Shared types and elaboration helpers for the APB burst accumulator.
// Holds the FSM state encoding and the parameter checks.
package apb_burst_acc_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   // A burst needs at least one beat, and the sum must hold one full data word.
   function automatic bit params_ok(input int burstLen, input int dataW, input int sumW);
      return (burstLen >= 1) && (sumW >= dataW);
   endfunction

   function automatic int beat_width(input int burstLen);
      return $clog2(burstLen + 1);
   endfunction

endpackage

// File: rtl/apb_burst_accumulator_if.sv
// APB bus bundle between the burst accumulator (master) and an APB slave.
interface apb_burst_accumulator_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
);
   logic              psel;
   logic              penable;
   logic              pwrite;
   logic [ADDR_W-1:0] paddr;
   logic [DATA_W-1:0] pwdata;
   logic [DATA_W-1:0] prdata;
   logic              pready;
   logic              pslverr;

   modport master (
      output psel, penable, pwrite, paddr, pwdata,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata,
      output prdata, pready, pslverr
   );
endinterface

// File: rtl/apb_burst_accumulator.sv
// APB read master: fetches BURST_LEN consecutive words and returns their sum,
// aborting with err_o on pslverr and chaining bursts back-to-back on start_i.
module apb_burst_accumulator
   import apb_burst_acc_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 8,
   parameter int BURST_LEN = 4,
   parameter int ADDR_STEP = 1,
   parameter int SUM_W     = DATA_W + 2
) (
   input  logic                     pclk_i,
   input  logic                     presetn_i,
   input  logic                     start_i,
   input  logic                     cont_i,
   input  logic [ADDR_W-1:0]        base_addr_i,
   apb_burst_accumulator_if.master  apb,
   output logic [SUM_W-1:0]         sum_o,
   output logic                     valid_o,
   output logic                     err_o,
   output logic                     busy_o
);

   if (!params_ok(BURST_LEN, DATA_W, SUM_W)) begin : g_bad_params
      $error("apb_burst_accumulator: BURST_LEN must be >= 1 and SUM_W >= DATA_W");
   end

   localparam int                BEAT_W    = beat_width(BURST_LEN);
   localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(ADDR_STEP);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   paddr_q, paddr_d;
   logic [ADDR_W-1:0]   lastAddr_q, lastAddr_d;
   logic [SUM_W-1:0]    acc_q, acc_d;
   logic [SUM_W-1:0]    sum_q, sum_d;
   logic [SUM_W-1:0]    accNext;
   logic [BEAT_W-1:0]   beat_q, beat_d;
   logic                valid_q, valid_d;
   logic                err_q, err_d;

   assign accNext = acc_q + SUM_W'(apb.prdata);

   // Next-state logic; on the final beat the restart address is based on
   // paddr_q because lastAddr_q is only being written on this same edge.
   always_comb begin
      state_d    = state_q;
      paddr_d    = paddr_q;
      lastAddr_d = lastAddr_q;
      acc_d      = acc_q;
      sum_d      = sum_q;
      beat_d     = beat_q;
      valid_d    = 1'b0;
      err_d      = err_q;

      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d = SETUP;
               paddr_d = cont_i ? lastAddr_q + STEP : base_addr_i;
               acc_d   = '0;
               beat_d  = '0;
            end
         end

         SETUP: begin
            state_d = ACCESS;
         end

         ACCESS: begin
            if (apb.pready) begin
               if (apb.pslverr) begin
                  state_d    = IDLE;
                  sum_d      = acc_q;
                  err_d      = 1'b1;
                  valid_d    = 1'b1;
                  lastAddr_d = paddr_q;
               end else if (beat_q == LAST_BEAT) begin
                  sum_d      = accNext;
                  err_d      = 1'b0;
                  valid_d    = 1'b1;
                  lastAddr_d = paddr_q;
                  acc_d      = accNext;
                  if (start_i) begin
                     state_d = SETUP;
                     paddr_d = cont_i ? paddr_q + STEP : base_addr_i;
                     acc_d   = '0;
                     beat_d  = '0;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  state_d = SETUP;
                  paddr_d = paddr_q + STEP;
                  acc_d   = accNext;
                  beat_d  = beat_q + 1'b1;
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge pclk_i or negedge presetn_i) begin
      if (!presetn_i) begin
         state_q    <= IDLE;
         paddr_q    <= '0;
         lastAddr_q <= '0;
         acc_q      <= '0;
         sum_q      <= '0;
         beat_q     <= '0;
         valid_q    <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         paddr_q    <= paddr_d;
         lastAddr_q <= lastAddr_d;
         acc_q      <= acc_d;
         sum_q      <= sum_d;
         beat_q     <= beat_d;
         valid_q    <= valid_d;
         err_q      <= err_d;
      end
   end

   // APB controls decode straight from the state register so reset drops them at once.
   assign apb.psel    = (state_q != IDLE);
   assign apb.penable = (state_q == ACCESS);
   assign apb.pwrite  = 1'b0;
   assign apb.paddr   = paddr_q;
   assign apb.pwdata  = '0;

   assign sum_o   = sum_q;
   assign valid_o = valid_q;
   assign err_o   = err_q;
   assign busy_o  = (state_q != IDLE);

endmodule

// File: tb/tb_apb_burst_accumulator.sv
// Self-checking bench: directed and randomized bursts against a burst-level model.
module tb_apb_burst_accumulator;

   localparam int DATA_W    = 32;
   localparam int ADDR_W    = 8;
   localparam int BURST_LEN = 4;
   localparam int ADDR_STEP = 1;
   localparam int SUM_W     = 33;

   typedef struct packed {
      logic             cont;
      logic [7:0]       base;
      logic [3:0][31:0] data;
      logic [3:0][1:0]  waits;
      logic [2:0]       errBeat;
   } burst_t;

   logic              pclk = 1'b0;
   logic              presetn = 1'b0;
   logic              start = 1'b0;
   logic              cont = 1'b0;
   logic [7:0]        baseAddr = 8'h00;
   logic [SUM_W-1:0]  sum;
   logic              valid;
   logic              err;
   logic              busy;

   int compared = 0;
   int mismatched = 0;

   logic [7:0]        modelLastAddr = 8'h00;
   logic [SUM_W-1:0]  modelSum = '0;
   logic              modelErr = 1'b0;

   apb_burst_accumulator_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) apbIf ();

   apb_burst_accumulator #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_LEN(BURST_LEN),
      .ADDR_STEP(ADDR_STEP), .SUM_W(SUM_W)
   ) dut (
      .pclk_i(pclk),
      .presetn_i(presetn),
      .start_i(start),
      .cont_i(cont),
      .base_addr_i(baseAddr),
      .apb(apbIf.master),
      .sum_o(sum),
      .valid_o(valid),
      .err_o(err),
      .busy_o(busy)
   );

   // Free-running clock
   always #5 pclk = ~pclk;

   // Safety net in case the stimulus ever stalls
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   function automatic burst_t mkBurst(input logic c, input logic [7:0] base,
                                      input logic [31:0] d0, input logic [31:0] d1,
                                      input logic [31:0] d2, input logic [31:0] d3);
      burst_t r;
      r.cont    = c;
      r.base    = base;
      r.data[0] = d0;
      r.data[1] = d1;
      r.data[2] = d2;
      r.data[3] = d3;
      r.waits   = '0;
      r.errBeat = 3'd7;
      return r;
   endfunction

   function automatic burst_t randBurst();
      burst_t r;
      r.cont = 1'($urandom_range(0, 1));
      r.base = 8'($urandom);
      for (int k = 0; k < 4; k++) begin
         r.data[k]  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
         r.waits[k] = 2'($urandom_range(0, 2));
      end
      r.errBeat = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 3)) : 3'd7;
      return r;
   endfunction

   // Runs one burst cycle by cycle, playing the APB slave and checking the master.
   task automatic applyStimulus(input burst_t b, input bit fromIdle, input bit chainAfter,
                                input burst_t nxt, output bit chained);
      logic [7:0]  addr;
      logic [63:0] total;
      int          last;
      bit          hasErr;

      hasErr = (b.errBeat < 3'd4);
      last   = hasErr ? int'(b.errBeat) : BURST_LEN - 1;
      addr   = b.cont ? modelLastAddr + 8'(ADDR_STEP) : b.base;
      total  = 64'd0;

      if (fromIdle) begin
         start    = 1'b1;
         cont     = b.cont;
         baseAddr = b.base;
         tick();
      end

      for (int k = 0; k <= last; k++) begin
         start    = 1'($urandom_range(0, 1));
         cont     = 1'($urandom_range(0, 1));
         baseAddr = 8'($urandom);
         checkOutput("setupCtrl", {62'd0, apbIf.psel, apbIf.penable}, 64'd2);
         checkOutput("setupAddr", {56'd0, apbIf.paddr}, {56'd0, addr});
         checkOutput("pwrite", {63'd0, apbIf.pwrite}, 64'd0);
         tick();
         checkOutput("accessCtrl", {62'd0, apbIf.psel, apbIf.penable}, 64'd3);
         checkOutput("accessValidLow", {63'd0, valid}, 64'd0);
         for (int w = 0; w < int'(b.waits[k]); w++) begin
            apbIf.pready  = 1'b0;
            apbIf.prdata  = 32'($urandom);
            apbIf.pslverr = 1'($urandom_range(0, 1));
            tick();
            checkOutput("waitHold", {54'd0, apbIf.psel, apbIf.penable, apbIf.paddr}, {54'd0, 2'b11, addr});
         end
         apbIf.pready  = 1'b1;
         apbIf.prdata  = b.data[k];
         apbIf.pslverr = (k == int'(b.errBeat));
         if (k == last) begin
            start    = chainAfter;
            cont     = nxt.cont;
            baseAddr = nxt.base;
         end
         if (k != int'(b.errBeat)) total = total + 64'(b.data[k]);
         tick();
         apbIf.pready  = 1'b0;
         apbIf.pslverr = 1'b0;
         start         = 1'b0;
         if (k < last) addr = addr + 8'(ADDR_STEP);
      end

      modelLastAddr = addr;
      modelSum      = total[SUM_W-1:0];
      modelErr      = hasErr;
      checkOutput("validPulse", {63'd0, valid}, 64'd1);
      checkOutput("sum", 64'(sum), 64'(modelSum));
      checkOutput("err", {63'd0, err}, {63'd0, modelErr});

      chained = chainAfter && !hasErr;
      if (chained) begin
         checkOutput("chainSetup", {62'd0, apbIf.psel, apbIf.penable}, 64'd2);
      end else begin
         checkOutput("idleBusy", {63'd0, busy}, 64'd0);
         checkOutput("idlePsel", {63'd0, apbIf.psel}, 64'd0);
         tick();
         checkOutput("validOnce", {63'd0, valid}, 64'd0);
         checkOutput("sumHold", 64'(sum), 64'(modelSum));
         checkOutput("errHold", {63'd0, err}, {63'd0, modelErr});
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "Ctrl"}, {61'd0, apbIf.psel, apbIf.penable, apbIf.pwrite}, 64'd0);
      checkOutput({tag, "Addr"}, {56'd0, apbIf.paddr}, 64'd0);
      checkOutput({tag, "Wdata"}, {32'd0, apbIf.pwdata}, 64'd0);
      checkOutput({tag, "Sum"}, 64'(sum), 64'd0);
      checkOutput({tag, "Flags"}, {61'd0, valid, err, busy}, 64'd0);
   endtask

   initial begin
      burst_t b;
      burst_t nb;
      bit     ch;

      apbIf.prdata  = '0;
      apbIf.pready  = 1'b0;
      apbIf.pslverr = 1'b0;
      ch = 1'b0;

      tick();
      checkAllZero("reset");
      tick();
      presetn = 1'b1;
      tick();
      checkAllZero("postReset");

      // Plain zero-wait burst
      b = mkBurst(1'b0, 8'h10, 32'd1, 32'd2, 32'd3, 32'd4);
      applyStimulus(b, 1'b1, 1'b0, b, ch);
      checkOutput("directSum10", 64'(sum), 64'd10);

      // Two wait states on the second beat
      b.waits[1] = 2'd2;
      applyStimulus(b, 1'b1, 1'b0, b, ch);

      // Slave error on the third beat, then a continuing burst after it
      b = mkBurst(1'b0, 8'h10, 32'd1, 32'd2, 32'hDEAD_BEEF, 32'd4);
      b.errBeat = 3'd2;
      applyStimulus(b, 1'b1, 1'b1, b, ch);
      checkOutput("errSum3", 64'(sum), 64'd3);
      b = mkBurst(1'b1, 8'h00, 32'd5, 32'd6, 32'd7, 32'd8);
      applyStimulus(b, 1'b1, 1'b0, b, ch);

      // Accumulator wrap at SUM_W bits
      b = mkBurst(1'b0, 8'h20, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      applyStimulus(b, 1'b1, 1'b0, b, ch);
      checkOutput("overflowSum", 64'(sum), 64'h1_FFFF_FFFC);

      // Address wrap through 0xFF
      b = mkBurst(1'b0, 8'hFE, 32'd9, 32'd9, 32'd9, 32'd9);
      applyStimulus(b, 1'b1, 1'b0, b, ch);

      // Back-to-back chaining with cont=1
      b  = mkBurst(1'b0, 8'h10, 32'd1, 32'd2, 32'd3, 32'd4);
      nb = mkBurst(1'b1, 8'h77, 32'd10, 32'd20, 32'd30, 32'd40);
      applyStimulus(b, 1'b1, 1'b1, nb, ch);
      applyStimulus(nb, !ch, 1'b0, nb, ch);
      checkOutput("chainLastAddr", {56'd0, modelLastAddr}, 64'h17);

      // Randomized bursts, with random chaining decisions
      b = randBurst();
      ch = 1'b0;
      for (int i = 0; i < 40; i++) begin
         nb = randBurst();
         applyStimulus(b, !ch, 1'($urandom_range(0, 1)), nb, ch);
         b = nb;
      end
      if (ch) applyStimulus(b, 1'b0, 1'b0, b, ch);

      // Reset in the middle of an ACCESS
      start    = 1'b1;
      cont     = 1'b0;
      baseAddr = 8'h40;
      tick();
      start = 1'b0;
      tick();
      checkOutput("preResetAccess", {62'd0, apbIf.psel, apbIf.penable}, 64'd3);
      presetn = 1'b0;
      #1;
      checkAllZero("midReset");
      tick();
      tick();
      presetn = 1'b1;
      modelLastAddr = 8'h00;
      tick();
      checkOutput("afterResetValid", {63'd0, valid}, 64'd0);
      checkOutput("afterResetBusy", {63'd0, busy}, 64'd0);

      // Continuing after reset starts from last_addr=0 plus one step
      b = mkBurst(1'b1, 8'h99, 32'd100, 32'd200, 32'd300, 32'd400);
      applyStimulus(b, 1'b1, 1'b0, b, ch);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
